// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit for the E stage.
// Owns HI/LO. One operation at a time under a start/busy handshake.
//   Clk, Reset    : clock, synchronous active-high reset
//   start, op     : launch op (0 mult,1 multu,2 div,3 divu,4 madd,5 maddu,6 mthi,7 mtlo)
//   A, B          : rs / rt operands
//   flush         : abort in-flight or launching operation
//   busy          : operation in flight (registered)
//   done          : one-cycle pulse when HI/LO take a mul/div result
//   HI, LO        : architectural HI/LO registers
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CMAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t r_state, w_next;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo, r_rem, r_quo;
  logic               r_msigned, r_madd, r_qneg, r_rneg, r_dz, r_done;

  // op decode: ops 0/1/4/5 multiply, 2/3 divide, 6/7 move-to
  logic w_op_mul, w_op_div, w_sgn;
  assign w_op_mul = ~op[1];
  assign w_op_div = op[1] & ~op[2];
  assign w_sgn    = ~op[0];

  logic w_last;
  assign w_last = (r_cnt == CW'(1));

  // Divide operands as magnitudes; abs of most-negative wraps to 2^(W-1),
  // which is the correct unsigned magnitude.
  logic [WIDTH-1:0] w_absa, w_absb;
  assign w_absa = (w_sgn && A[WIDTH-1]) ? -A : A;
  assign w_absb = (w_sgn && B[WIDTH-1]) ? -B : B;

  // Multiply: extend to 2W so the low 2W bits of the product are exact
  // for both signed and unsigned operands.
  logic [2*WIDTH-1:0] w_ea, w_eb, w_prod, w_mres;
  assign w_ea   = r_msigned ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_eb   = r_msigned ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_ea * w_eb;
  assign w_mres = r_madd ? ({r_hi, r_lo} + w_prod) : w_prod;

  // Restoring step: remainder < divisor always, so the shifted value fits
  // W+1 bits and the kept remainder fits W bits.
  logic [WIDTH:0] w_sh, w_diff;
  assign w_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_b};

  logic [WIDTH-1:0] w_q, w_r;
  assign w_q = r_qneg ? -r_quo : r_quo;
  assign w_r = r_rneg ? -r_rem : r_rem;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) begin
        if (w_op_mul)      w_next = S_MUL;
        else if (w_op_div) w_next = S_DIV;
      end
      S_MUL:  if (w_last) w_next = S_IDLE;
      S_DIV:  if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_msigned <= 1'b0;
      r_madd    <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_dz      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!flush) begin
        case (r_state)
          S_IDLE: if (start) begin
            if (w_op_mul) begin
              r_a       <= A;
              r_b       <= B;
              r_msigned <= w_sgn;
              r_madd    <= op[2];
              r_cnt     <= CW'(MUL_CYCLES);
            end else if (w_op_div) begin
              r_quo  <= w_absa;
              r_b    <= w_absb;
              r_rem  <= '0;
              r_qneg <= w_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
              r_rneg <= w_sgn & A[WIDTH-1];
              r_dz   <= (B == '0);
              r_cnt  <= CW'(WIDTH);
            end else if (!op[0]) begin
              r_hi <= A;
            end else begin
              r_lo <= A;
            end
          end
          S_MUL: begin
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
              {r_hi, r_lo} <= w_mres;
              r_done       <= 1'b1;
            end
          end
          S_DIV: begin
            r_cnt <= r_cnt - CW'(1);
            if (!w_diff[WIDTH]) r_rem <= w_diff[WIDTH-1:0];
            else                r_rem <= w_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          end
          S_FIX: begin
            r_done <= 1'b1;
            if (!r_dz) begin
              r_lo <= w_q;
              r_hi <= w_r;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=5).
// Stimulus pushes expected {HI,LO} into a queue; a monitor pops on done.
module tb_mdu_iter;
  localparam int W  = 32;
  localparam int MC = 5;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op_i = '0;
  logic [W-1:0]  A = '0, B = '0;
  logic          flush = 1'b0;
  logic          busy, done;
  logic [W-1:0]  HI, LO;

  mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op_i), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  logic [63:0] q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding result.
  always @(negedge Clk) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("result_hilo", {HI, LO}, q.pop_front());
    end
  end

  // Reference model from the architectural definition.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit push, output int lat);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    longint qq, rr;
    push = 1'b0; lat = 0;
    case (o)
      3'd0, 3'd1, 3'd4, 3'd5: begin
        if (o[0] == 1'b0) begin sa = $signed(a); sb = $signed(b); p = sa * sb; end
        else p = {32'b0, a} * {32'b0, b};
        if (o[2]) p = {m_hi, m_lo} + p;
        {m_hi, m_lo} = p;
        push = 1'b1; lat = MC;
      end
      3'd2, 3'd3: begin
        if (b != '0) begin
          if (o == 3'd2) begin
            qq = longint'($signed(a)) / longint'($signed(b));
            rr = longint'($signed(a)) % longint'($signed(b));
            m_lo = qq[31:0]; m_hi = rr[31:0];
          end else begin
            m_lo = a / b; m_hi = a % b;
          end
        end
        push = 1'b1; lat = W + 1;
      end
      3'd6: m_hi = a;
      default: m_lo = a;
    endcase
  endtask

  // Called at a negedge; returns at the negedge where busy has dropped
  // (the done cycle), so a following call exercises back-to-back issue.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inj);
    bit push; int lat; int n;
    model(o, a, b, push, lat);
    if (push) q.push_back({m_hi, m_lo});
    start = 1'b1; op_i = o; A = a; B = b;
    @(negedge Clk);
    start = 1'b0;
    if (!push) begin
      chk("mt_busy", {63'b0, busy}, 64'd0);
      chk("mt_hilo", {HI, LO}, {m_hi, m_lo});
    end else begin
      n = 0;
      while (busy && n < 100) begin
        n++;
        if (inj && n == 2) begin start = 1'b1; op_i = 3'd7; A = 32'hDEADBEEF; end
        else start = 1'b0;
        @(negedge Clk);
      end
      start = 1'b0;
      chk("latency", 64'(n), 64'(lat));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0] ro;
    repeat (2) @(negedge Clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    chk("plan_multu", {HI, LO}, 64'hFFFFFFFE_00000001);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 0);
    chk("plan_div_neg7", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("plan_divu", {HI, LO}, 64'h80000000_00000000);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("plan_div_ovf", {HI, LO}, 64'h00000000_80000000);
    do_op(3'd6, 32'h11, 32'h0, 0);
    do_op(3'd7, 32'h22, 32'h0, 0);
    do_op(3'd2, 32'd5, 32'd0, 0);
    chk("plan_div0", {HI, LO}, 64'h00000011_00000022);
    do_op(3'd6, 32'h1, 32'h0, 0);
    do_op(3'd7, 32'hFFFFFFFF, 32'h0, 0);
    do_op(3'd4, 32'd2, 32'd3, 1);
    chk("plan_madd", {HI, LO}, 64'h00000002_00000005);

    // flush of an in-flight divu
    start = 1'b1; op_i = 3'd3; A = 32'd1000; B = 32'd7;
    @(negedge Clk); start = 1'b0;
    repeat (9) @(negedge Clk);
    flush = 1'b1;
    @(negedge Clk); flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_hilo", {HI, LO}, {m_hi, m_lo});
    repeat (40) @(negedge Clk);
    // same-cycle flush + mthi is discarded
    start = 1'b1; op_i = 3'd6; A = 32'h12345678; flush = 1'b1;
    @(negedge Clk); start = 1'b0; flush = 1'b0;
    chk("flush_mthi", {HI, LO}, {m_hi, m_lo});
    chk("flush_mthi_busy", {63'b0, busy}, 64'd0);

    // reset during a multiply
    start = 1'b1; op_i = 3'd0; A = 32'd5; B = 32'd7;
    @(negedge Clk); start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_done", {63'b0, done}, 64'd0);
    chk("rst_mid_hilo", {HI, LO}, 64'd0);
    m_hi = '0; m_lo = '0;
    do_op(3'd0, 32'hFFFFFFFD, 32'd4, 0);
    chk("post_rst_mult", {HI, LO}, 64'hFFFFFFFF_FFFFFFF4);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      do_op(ro, ra, rb, ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge Clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
